// File: rtl/spin_encoder.sv
// spin_encoder: frame-ticked digital/mouse rotary angle accumulator with slow->fast ramp.
// Ports: clk, reset (sync, active-high); strobe (frame ref, rising edge = tick);
// plus/minus (digital rotate CW/CCW); fast (force fast step); mouse_en, mouse_x
// (signed delta), mouse_strobe (mouse valid); spin_angle (top accumulator bits);
// dir (last digital direction, 1 = plus); step_pulse (spin_angle just changed).
module spin_encoder #(
  parameter int ANGLE_W    = 4,
  parameter int FRAC_W     = 4,
  parameter int STEP_SLOW  = 4,
  parameter int STEP_FAST  = 16,
  parameter int RAMP_TICKS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               strobe,
  input  logic               plus,
  input  logic               minus,
  input  logic               fast,
  input  logic               mouse_en,
  input  logic [8:0]         mouse_x,
  input  logic               mouse_strobe,
  output logic [ANGLE_W-1:0] spin_angle,
  output logic               dir,
  output logic               step_pulse
);
  localparam int AW = ANGLE_W + FRAC_W;
  localparam int CW = $clog2(RAMP_TICKS + 1);
  localparam logic [1:0] IDLE = 2'd0, RAMP = 2'd1, RUN = 2'd2;
  logic [AW-1:0] acc, acc_n, step, delta;
  logic [1:0] state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic strobe_d, tick, pl, mi, go, same, dir_n;
  assign spin_angle = acc[AW-1:FRAC_W];
  always_comb begin
    tick    = strobe & ~strobe_d;
    pl      = plus & ~minus;
    mi      = minus & ~plus;
    go      = tick & (pl | mi);
    same    = (state != IDLE) && (pl == dir);
    step    = (state == RUN || fast) ? AW'(STEP_FAST) : AW'(STEP_SLOW);
    delta   = (mouse_strobe & mouse_en) ? AW'($signed(mouse_x)) : '0;
    acc_n   = acc + delta + (go ? (pl ? step : -step) : '0);
    dir_n   = go ? pl : dir;
    cnt_n   = go ? (same ? (state == RUN ? cnt : cnt + CW'(1)) : CW'(1)) : tick ? '0 : cnt;
    // A same-direction tick in RUN stays there; otherwise the ramp count decides.
    state_n = go ? (((state == RUN && same) || cnt_n == CW'(RAMP_TICKS)) ? RUN : RAMP)
                 : tick ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      dir        <= 1'b1;
      step_pulse <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      strobe_d   <= 1'b1;
    end else begin
      acc        <= acc_n;
      dir        <= dir_n;
      step_pulse <= acc_n[AW-1:FRAC_W] != acc[AW-1:FRAC_W];
      state      <= state_n;
      cnt        <= cnt_n;
      strobe_d   <= strobe;
    end
  end
endmodule

// File: tb/tb_spin_encoder.sv
// tb_spin_encoder: randomized + directed check of spin_encoder against a streak-based model.
module tb_spin_encoder;
  localparam int SLOW = 4, FAST = 16, RT = 8;
  logic clk = 0, reset, strobe, plus, minus, fast, mouse_en, mouse_strobe;
  logic [8:0] mouse_x;
  logic [3:0] spin_angle;
  logic dir, step_pulse;
  int tests = 0, fails = 0;
  int macc, streak, old;
  logic mdir, mpulse, mstrobe_d;
  spin_encoder dut (
    .clk(clk), .reset(reset), .strobe(strobe), .plus(plus), .minus(minus),
    .fast(fast), .mouse_en(mouse_en), .mouse_x(mouse_x), .mouse_strobe(mouse_strobe),
    .spin_angle(spin_angle), .dir(dir), .step_pulse(step_pulse)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  // Model: RUN is simply "at least RT consecutive same-direction ticks so far".
  task automatic model();
    bit tk, p, m;
    int st;
    if (reset) begin
      macc = 0; mdir = 1; streak = 0; mpulse = 0; mstrobe_d = 1;
      return;
    end
    tk = strobe && !mstrobe_d;
    mstrobe_d = strobe;
    old = macc;
    p = plus && !minus;
    m = minus && !plus;
    if (tk && (p || m)) begin
      st = (streak >= RT || fast) ? FAST : SLOW;
      macc += p ? st : -st;
      streak = (streak > 0 && p == mdir) ? streak + 1 : 1;
      mdir = p;
    end else if (tk) streak = 0;
    if (mouse_strobe && mouse_en) macc += int'($signed(mouse_x));
    macc &= 255;
    mpulse = (old >> 4) != (macc >> 4);
  endtask
  task automatic cyc(input bit r, input bit s, input bit p, input bit m, input bit f,
                     input bit me, input int mx, input bit ms);
    reset = r; strobe = s; plus = p; minus = m; fast = f;
    mouse_en = me; mouse_x = 9'(mx); mouse_strobe = ms;
    @(posedge clk);
    model();
    #1;
    chk("spin_angle", int'(spin_angle), macc >> 4);
    chk("dir", int'(dir), int'(mdir));
    chk("step_pulse", int'(step_pulse), int'(mpulse));
  endtask
  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic tick(input bit p, input bit m, input bit f);
    cyc(0, 0, p, m, f, 0, 0, 0);
    cyc(0, 1, p, m, f, 0, 0, 0);
  endtask
  initial begin
    int pulses;
    bit s, p, m;
    do_reset();
    chk("reset_angle", int'(spin_angle), 0);
    chk("reset_dir", int'(dir), 1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0);
      pulses += int'(step_pulse);
    end
    chk("plus4_angle", int'(spin_angle), 1);
    chk("plus4_pulse", pulses, 1);
    do_reset();
    for (int i = 0; i < 12; i++) tick(1, 0, 0);
    chk("plus12_angle", int'(spin_angle), 6);
    chk("plus12_acc", macc, 96);
    do_reset();
    tick(0, 1, 1);
    chk("minus_fast_angle", int'(spin_angle), 15);
    chk("minus_fast_dir", int'(dir), 0);
    do_reset();
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1, 1, 0);
      pulses += int'(step_pulse);
    end
    chk("both_angle", int'(spin_angle), 0);
    chk("both_pulses", pulses, 0);
    do_reset();
    cyc(0, 0, 1, 0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0, 1, -3, 1);
    chk("mouse_tick_acc", macc, 1);
    chk("mouse_tick_angle", int'(spin_angle), 0);
    cyc(0, 1, 0, 0, 0, 1, 15, 1);
    chk("mouse_p15_angle", int'(spin_angle), 1);
    chk("mouse_p15_pulse", int'(step_pulse), 1);
    cyc(0, 1, 0, 0, 0, 0, 100, 1);
    chk("mouse_dis_angle", int'(spin_angle), 1);
    do_reset();
    for (int i = 0; i < 12; i++) tick(1, 0, 0);
    chk("run_angle", int'(spin_angle), 6);
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 0, 0, 0);
    chk("post_reset_angle", int'(spin_angle), 0);
    cyc(0, 1, 1, 0, 1, 0, 0, 0);
    chk("held_strobe_angle", int'(spin_angle), 0);
    tick(1, 0, 1);
    chk("retick_angle", int'(spin_angle), 1);
    do_reset();
    s = 0; p = 1; m = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) s = ~s;
      if ($urandom_range(0, 60) == 0) begin
        p = 1'($urandom);
        m = 1'($urandom);
      end
      cyc($urandom_range(0, 300) == 0, s, p, m, $urandom_range(0, 7) == 0,
          1'($urandom), int'($urandom_range(0, 511)), $urandom_range(0, 5) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
